// File: rtl/rgb2gray_pipe_if.sv
// Pixel-stream bundle for the RGB-to-grayscale stage.
// master: camera side / testbench, drives pixel input and mode request,
//         observes gray result, frame markers and frame pixel count.
// slave : rgb2gray_pipe, consumes pixels and produces the results.
interface rgb2gray_pipe_if #(
    parameter int unsigned R_BITS     = 5,
    parameter int unsigned G_BITS     = 6,
    parameter int unsigned B_BITS     = 5,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned COUNT_BITS = 17
);
    localparam int unsigned PIX_BITS = R_BITS + G_BITS + B_BITS;

    logic [PIX_BITS-1:0]   pixel_data_in;
    logic                  pixel_valid;
    logic                  frame_done;
    logic [1:0]            mode_in;
    logic [OUT_BITS-1:0]   gray;
    logic                  pixel_valid_out;
    logic                  frame_done_out;
    logic [1:0]            mode_active;
    logic [COUNT_BITS-1:0] frame_pixels;
    logic                  frame_pixels_valid;

    modport master (
        output pixel_data_in, pixel_valid, frame_done, mode_in,
        input  gray, pixel_valid_out, frame_done_out, mode_active,
               frame_pixels, frame_pixels_valid
    );

    modport slave (
        input  pixel_data_in, pixel_valid, frame_done, mode_in,
        output gray, pixel_valid_out, frame_done_out, mode_active,
               frame_pixels, frame_pixels_valid
    );
endinterface

// File: rtl/rgb2gray_pipe.sv
// Three-stage pipelined RGB-to-grayscale converter with frame-boundary mode
// switching and per-frame accepted-pixel counting.
// Ports:
//   clk_in  : clock, all logic on rising edge
//   rst_in  : synchronous active-high reset
//   bus     : rgb2gray_pipe_if.slave
//             in : pixel_data_in {R,G,B}, pixel_valid, frame_done, mode_in
//             out: gray, pixel_valid_out, frame_done_out (3-cycle aligned),
//                  mode_active, frame_pixels, frame_pixels_valid
module rgb2gray_pipe #(
    parameter int unsigned R_BITS     = 5,
    parameter int unsigned G_BITS     = 6,
    parameter int unsigned B_BITS     = 5,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned COUNT_BITS = 17
) (
    input  logic           clk_in,
    input  logic           rst_in,
    rgb2gray_pipe_if.slave bus
);
    localparam int unsigned PIX_BITS  = R_BITS + G_BITS + B_BITS;
    localparam int unsigned PROD_BITS = OUT_BITS + 8;
    localparam int unsigned SUM_BITS  = OUT_BITS + 10;
    localparam int unsigned Q_BITS    = SUM_BITS - 8;

    localparam logic [1:0] MODE_LUMA  = 2'd0;
    localparam logic [1:0] MODE_AVG   = 2'd1;
    localparam logic [1:0] MODE_GREEN = 2'd2;

    localparam logic [7:0] W_LUMA_R = 8'd77;
    localparam logic [7:0] W_LUMA_G = 8'd150;
    localparam logic [7:0] W_LUMA_B = 8'd29;
    localparam logic [7:0] W_AVG_R  = 8'd85;
    localparam logic [7:0] W_AVG_G  = 8'd86;
    localparam logic [7:0] W_AVG_B  = 8'd85;

    localparam logic [OUT_BITS-1:0]   GRAY_MAX  = '1;
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    typedef enum logic {RUN, SWITCH} state_t;

    state_t state;
    state_t state_next;
    logic   frame_rise_c;
    logic   accept_c;

    logic [R_BITS-1:0]   r_field_c;
    logic [G_BITS-1:0]   g_field_c;
    logic [B_BITS-1:0]   b_field_c;
    logic [OUT_BITS-1:0] r_exp_c;
    logic [OUT_BITS-1:0] g_exp_c;
    logic [OUT_BITS-1:0] b_exp_c;

    logic                s1_valid;
    logic [1:0]          s1_mode;
    logic [OUT_BITS-1:0] s1_r;
    logic [OUT_BITS-1:0] s1_g;
    logic [OUT_BITS-1:0] s1_b;
    logic [OUT_BITS-1:0] s1_raw;

    logic [7:0]          w_r_c;
    logic [7:0]          w_g_c;
    logic [7:0]          w_b_c;

    logic                 s2_valid;
    logic [1:0]           s2_mode;
    logic [PROD_BITS-1:0] s2_pr;
    logic [PROD_BITS-1:0] s2_pg;
    logic [PROD_BITS-1:0] s2_pb;
    logic [OUT_BITS-1:0]  s2_g;
    logic [OUT_BITS-1:0]  s2_raw;

    logic [SUM_BITS-1:0]  sum_c;
    logic [Q_BITS-1:0]    q_c;
    logic [OUT_BITS-1:0]  mix_c;
    logic [OUT_BITS-1:0]  result_c;

    logic [1:0]            fd_sr;
    logic [COUNT_BITS-1:0] pix_count;

    assign accept_c  = bus.pixel_valid && !bus.frame_done;
    assign r_field_c = bus.pixel_data_in[PIX_BITS-1 -: R_BITS];
    assign g_field_c = bus.pixel_data_in[B_BITS +: G_BITS];
    assign b_field_c = bus.pixel_data_in[B_BITS-1:0];

    // Channel expansion: field followed by its own MSBs to fill OUT_BITS
    if (R_BITS == OUT_BITS) begin : g_r_full
        assign r_exp_c = r_field_c;
    end else begin : g_r_rep
        assign r_exp_c = {r_field_c, r_field_c[R_BITS-1 -: OUT_BITS-R_BITS]};
    end
    if (G_BITS == OUT_BITS) begin : g_g_full
        assign g_exp_c = g_field_c;
    end else begin : g_g_rep
        assign g_exp_c = {g_field_c, g_field_c[G_BITS-1 -: OUT_BITS-G_BITS]};
    end
    if (B_BITS == OUT_BITS) begin : g_b_full
        assign b_exp_c = b_field_c;
    end else begin : g_b_rep
        assign b_exp_c = {b_field_c, b_field_c[B_BITS-1 -: OUT_BITS-B_BITS]};
    end

    // Mode FSM state register; SWITCH means frame_done was high last cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Mode FSM next state; the RUN->SWITCH transition is the frame boundary
    always_comb begin
        state_next   = state;
        frame_rise_c = 1'b0;
        case (state)
            RUN: begin
                if (bus.frame_done) begin
                    state_next   = SWITCH;
                    frame_rise_c = 1'b1;
                end
            end
            SWITCH: begin
                if (!bus.frame_done) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Active mode: reloaded only at reset or a frame boundary
    always_ff @(posedge clk_in) begin
        if (rst_in || frame_rise_c) begin
            bus.mode_active <= bus.mode_in;
        end
    end

    // Stage 1: expanded channels, raw bits, and the mode this pixel uses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_raw   <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_mode <= bus.mode_active;
                s1_r    <= r_exp_c;
                s1_g    <= g_exp_c;
                s1_b    <= b_exp_c;
                s1_raw  <= bus.pixel_data_in[OUT_BITS-1:0];
            end
        end
    end

    // Weight set per stage-1 mode; both sets sum to 256
    always_comb begin
        w_r_c = W_LUMA_R;
        w_g_c = W_LUMA_G;
        w_b_c = W_LUMA_B;
        if (s1_mode == MODE_AVG) begin
            w_r_c = W_AVG_R;
            w_g_c = W_AVG_G;
            w_b_c = W_AVG_B;
        end
    end

    // Stage 2: per-channel products
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_mode  <= '0;
            s2_pr    <= '0;
            s2_pg    <= '0;
            s2_pb    <= '0;
            s2_g     <= '0;
            s2_raw   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_pr   <= PROD_BITS'(s1_r) * PROD_BITS'(w_r_c);
                s2_pg   <= PROD_BITS'(s1_g) * PROD_BITS'(w_g_c);
                s2_pb   <= PROD_BITS'(s1_b) * PROD_BITS'(w_b_c);
                s2_g    <= s1_g;
                s2_raw  <= s1_raw;
            end
        end
    end

    // Stage 3 datapath: round-half-up divide by 256 with clamp, mode select
    always_comb begin
        sum_c = SUM_BITS'(s2_pr) + SUM_BITS'(s2_pg) + SUM_BITS'(s2_pb)
              + SUM_BITS'(128);
        q_c   = Q_BITS'(sum_c >> 8);
        mix_c = (q_c > Q_BITS'(GRAY_MAX)) ? GRAY_MAX : q_c[OUT_BITS-1:0];
        case (s2_mode)
            MODE_LUMA, MODE_AVG: result_c = mix_c;
            MODE_GREEN:          result_c = s2_g;
            default:             result_c = s2_raw;
        endcase
    end

    // Stage 3 register; gray holds between valid results
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.gray            <= '0;
            bus.pixel_valid_out <= 1'b0;
        end else begin
            bus.pixel_valid_out <= s2_valid;
            if (s2_valid) begin
                bus.gray <= result_c;
            end
        end
    end

    // frame_done delay line, ungated, matched to the pixel latency
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fd_sr              <= '0;
            bus.frame_done_out <= 1'b0;
        end else begin
            fd_sr              <= {fd_sr[0], bus.frame_done};
            bus.frame_done_out <= fd_sr[1];
        end
    end

    // Saturating accepted-pixel counter, snapshotted at each frame boundary
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pix_count              <= '0;
            bus.frame_pixels       <= '0;
            bus.frame_pixels_valid <= 1'b0;
        end else begin
            bus.frame_pixels_valid <= frame_rise_c;
            if (frame_rise_c) begin
                bus.frame_pixels <= pix_count;
                pix_count        <= '0;
            end else if (accept_c && (pix_count != COUNT_MAX)) begin
                pix_count <= pix_count + COUNT_BITS'(1);
            end
        end
    end
endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
Parametrised, pipelined successor of the camera-path RGB-to-grayscale stage. It accepts one packed RGB pixel per clock with a valid qualifier and expands each channel to OUT_BITS by MSB replication. It converts using a runtime-selectable mode (luma, average, green-only, raw passthrough) and emits gray with valid and frame_done aligned to the pipeline latency. It sits between the camera capture block and the frame buffer / downstream filters, and also reports the number of pixels accepted per frame.

Parameters:
R_BITS, 5, red field width (MSBs of pixel word)
G_BITS, 6, green field width (middle field)
B_BITS, 5, blue field width (LSBs of pixel word)
OUT_BITS, 8, gray output width; each channel width must satisfy OUT_BITS/2 <= width <= OUT_BITS
COUNT_BITS, 17, frame pixel counter width (320x240 = 76800 fits)

Ports:
clk_in  input  1  system clock; all logic on posedge
rst_in  input  1  synchronous active-high reset
pixel_data_in  input  R_BITS+G_BITS+B_BITS  packed pixel {R,G,B}
pixel_valid  input  1  pixel_data_in valid this cycle
frame_done  input  1  high between frames; pixels are ignored while high
mode_in  input  2  requested mode: 0 luma, 1 average, 2 green-only, 3 raw low OUT_BITS of pixel
gray  output  OUT_BITS  grayscale result
pixel_valid_out  output  1  gray valid this cycle
frame_done_out  output  1  frame_done delayed by LATENCY
mode_active  output  2  mode currently in effect
frame_pixels  output  COUNT_BITS  pixels accepted in last completed frame
frame_pixels_valid  output  1  one-cycle pulse when frame_pixels updates

Behaviour:
- Reset: the synchronous, active-high rst_in is sampled on posedge clk_in. It clears all outputs (gray, pixel_valid_out, frame_done_out, frame_pixels, frame_pixels_valid) and all pipeline valid bits to 0, clears the pixel counter, and loads mode_active <= mode_in. Reset asserted mid-frame discards in-flight pixels; pixel_valid_out is never asserted for them.
- Accept: a pixel is accepted when pixel_valid && !frame_done. Non-accepted cycles inject a bubble (stage valid = 0).
- LATENCY = 3 clocks from an accepting edge to pixel_valid_out high with the result. gray holds its last value while pixel_valid_out = 0.
- Stage 1: register each channel expanded to OUT_BITS as {field, field MSBs} (e.g. 5-bit 10101 -> 10101101; 6-bit 101011 -> 10101110). Also register the raw low OUT_BITS and the valid bit.
- Stage 2: per-channel products, weights summing to 256. Luma uses R*77, G*150, B*29. Average uses R*85, G*86, B*85. Product width is OUT_BITS+8.
- Stage 3: sum + 128, then >>8 (round half up). The result provably fits OUT_BITS (white -> all ones); a clamp to all ones is still required. Green-only mode outputs expanded G; raw mode outputs the registered low OUT_BITS.
- frame_done_out is frame_done passed through a 3-deep shift register with no gating, so it stays aligned with gray.
- Mode FSM, states RUN and SWITCH:
  - mode_active changes only at a frame boundary. On the rising edge of frame_done (registered previous value 0, current value 1), mode_active <= mode_in.
  - Pixels already in the pipe finish in the mode latched when they were accepted. Mode is carried per stage alongside valid.
  - mode_in changes mid-frame have no effect until the next boundary.
- Pixel counter:
  - Increments on each accepted pixel and saturates at all ones.
  - On the frame_done rising edge: frame_pixels <= counter (including any pixel accepted that same cycle, which is impossible since frame_done = 1 blocks acceptance), counter <= 0, frame_pixels_valid = 1 for exactly one cycle.
  - frame_done held high for multiple cycles produces one pulse only.
- Simultaneous frame_done rise and mode_in change: the new mode_in value is latched.

Test Plan:
- Reset, mode_in = 0, then pixel_data_in = 16'hFFFF with pixel_valid = 1 -> 3 cycles later gray = 8'd255, pixel_valid_out = 1 for one cycle.
- Luma mode, back-to-back pixels 16'hF800, 16'h07E0, 16'h001F -> gray = 77, 149, 29 on consecutive cycles; pixel_valid_out held high for 3 cycles.
- Average mode (set before frame_done rise), pixel 16'hF800 -> gray = 85. Green-only mode, 16'h07E0 -> gray = 255. Raw mode, 16'h07E0 -> gray = 8'hE0.
- Mode change mid-frame: mode_active = 0, change mode_in to 1 mid-frame, send 16'hF800 -> gray = 77. After a frame_done pulse, the same pixel -> gray = 85; mode_active = 1.
- Counting: 5 accepted pixels plus 2 with pixel_valid = 1 while frame_done = 1, then frame_done held 4 cycles -> one frame_pixels_valid pulse, frame_pixels = 5. frame_done_out mirrors frame_done 3 cycles late.
- Reset mid-stream: assert rst_in with 2 pixels in flight -> no pixel_valid_out for them, gray = 0, counter cleared. The next frame's count excludes pre-reset pixels.
